mat_stream_loader: RTL and testbench

//   Deserialises a stream of 32-bit elements, arriving in row-major order, into a packed
//   M x N matrix [M-1:0][N-1:0][31:0]. It feeds mat_transpose and the other packed-matrix

---
 rtl/mat_stream_loader.sv | 129 ++++++++++++
 tb/tb_mat_stream_loader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mat_stream_loader.sv
`default_nettype none
// ============================================================================
//  Module      : mat_stream_loader
//  Description : Collects a row-major stream of 32-bit elements into a packed
//                M x N matrix. Elements come in on a valid/ready handshake and
//                the matrix goes out on a second one. There is a single buffer,
//                so a finished matrix is held until the consumer takes it.
//  Revision    : 1.0 - initial release
// ============================================================================
module mat_stream_loader #(
   parameter int M = 2,
   parameter int N = 3
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [31:0]                in_data,
   input  logic                       in_valid,
   input  logic                       in_last,
   output logic                       in_ready,
   output logic [M-1:0][N-1:0][31:0]  out_mat,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       err_frame
);

   // Counters keep at least one bit so that M=1 or N=1 still elaborate.
   localparam int c_row_w = (M > 1) ? $clog2(M) : 1;
   localparam int c_col_w = (N > 1) ? $clog2(N) : 1;
   localparam logic [c_row_w-1:0] c_row_last = c_row_w'(M - 1);
   localparam logic [c_col_w-1:0] c_col_last = c_col_w'(N - 1);

   typedef enum logic [0:0] {
      ST_LOAD = 1'b0,
      ST_FULL = 1'b1
   } state_t;

   state_t                      r_state;
   state_t                      w_state_nxt;
   logic [c_row_w-1:0]          r_row;
   logic [c_row_w-1:0]          w_row_nxt;
   logic [c_col_w-1:0]          r_col;
   logic [c_col_w-1:0]          w_col_nxt;
   logic [M-1:0][N-1:0][31:0]   r_mat;
   logic                        r_in_ready;
   logic                        r_out_valid;
   logic                        r_err;
   logic                        w_err_nxt;
   logic                        w_accept;
   logic                        w_at_end;

   // An element is only taken while the registered ready is high, so the
   // cycle straight after reset release never accepts.
   assign w_accept = in_valid && r_in_ready;
   assign w_at_end = (r_row == c_row_last) && (r_col == c_col_last);

   // Next-state, position and framing-error decode.
   always_comb begin
      w_state_nxt = r_state;
      w_row_nxt   = r_row;
      w_col_nxt   = r_col;
      w_err_nxt   = 1'b0;
      case (r_state)
         ST_LOAD: begin
            if (w_accept) begin
               if (w_at_end) begin
                  // Matrix completes even without in_last; flag the mismatch.
                  w_state_nxt = ST_FULL;
                  w_row_nxt   = '0;
                  w_col_nxt   = '0;
                  w_err_nxt   = !in_last;
               end else if (in_last) begin
                  // Early last: abandon the partial frame, stale cells remain.
                  w_row_nxt   = '0;
                  w_col_nxt   = '0;
                  w_err_nxt   = 1'b1;
               end else if (r_col == c_col_last) begin
                  w_col_nxt   = '0;
                  w_row_nxt   = r_row + c_row_w'(1);
               end else begin
                  w_col_nxt   = r_col + c_col_w'(1);
               end
            end
         end
         ST_FULL: begin
            if (r_out_valid && out_ready) begin
               w_state_nxt = ST_LOAD;
            end
         end
         default: begin
            w_state_nxt = ST_LOAD;
         end
      endcase
   end

   // State, counters and registered handshake/error outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_LOAD;
         r_row       <= '0;
         r_col       <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_row       <= w_row_nxt;
         r_col       <= w_col_nxt;
         r_in_ready  <= (w_state_nxt == ST_LOAD);
         r_out_valid <= (w_state_nxt == ST_FULL);
         r_err       <= w_err_nxt;
      end
   end

   // Matrix storage: written one cell per accepted element, otherwise held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mat <= '0;
      end else if (w_accept) begin
         r_mat[r_row][r_col] <= in_data;
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_mat   = r_mat;
   assign err_frame = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mat_stream_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mat_stream_loader
//  Description : Self-checking bench for mat_stream_loader (M=2, N=3) using a
//                vector table, directed corner sequences and random traffic
//                compared against a frame-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mat_stream_loader;

   localparam int M  = 2;
   localparam int N  = 3;
   localparam int MN = M * N;

   logic                      clk;
   logic                      rst_n;
   logic [31:0]               in_data;
   logic                      in_valid;
   logic                      in_last;
   logic                      in_ready;
   logic [M-1:0][N-1:0][31:0] out_mat;
   logic                      out_valid;
   logic                      out_ready;
   logic                      err_frame;

   int total;
   int bad;
   int err_seen;
   int valid_seen;

   // Reference model: a flat element array and a linear fill position.
   logic [31:0] m_cells [MN];
   int          m_pos;
   logic        m_ready;
   logic        m_valid;
   logic        m_err;

   typedef struct {
      logic        v;
      logic [31:0] d;
      logic        l;
      logic        ordy;
      logic        e_rdy;
      logic        e_val;
      logic        e_err;
   } vec_t;

   vec_t tbl [8];

   mat_stream_loader #(.M(M), .N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_mat   (out_mat),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .err_frame (err_frame)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
      $fatal(1);
   end

   function automatic logic [MN*32-1:0] model_mat();
      logic [M-1:0][N-1:0][31:0] m;
      for (int k = 0; k < MN; k++) m[k / N][k % N] = m_cells[k];
      return m;
   endfunction

   function automatic logic [MN*32-1:0] mk_mat(input int base);
      logic [M-1:0][N-1:0][31:0] m;
      for (int k = 0; k < MN; k++) m[k / N][k % N] = 32'(base + k);
      return m;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < MN; k++) m_cells[k] = '0;
      m_pos   = 0;
      m_ready = 1'b0;
      m_valid = 1'b0;
      m_err   = 1'b0;
   endtask

   // One rising edge of the loader, described per frame rules.
   task automatic model_edge(input logic v, input logic [31:0] d, input logic l, input logic ordy);
      m_err = 1'b0;
      if (m_valid) begin
         if (ordy) m_valid = 1'b0;
      end else if (v && m_ready) begin
         m_cells[m_pos] = d;
         if (m_pos == MN - 1) begin
            m_valid = 1'b1;
            m_pos   = 0;
            m_err   = !l;
         end else if (l) begin
            m_pos = 0;
            m_err = 1'b1;
         end else begin
            m_pos++;
         end
      end
      m_ready = !m_valid;
   endtask

   task automatic chk(input string nm, input logic [MN*32-1:0] act, input logic [MN*32-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_model(input string nm);
      chk({nm, "_rdy"}, in_ready, m_ready);
      chk({nm, "_val"}, out_valid, m_valid);
      chk({nm, "_err"}, err_frame, m_err);
      chk({nm, "_mat"}, out_mat, model_mat());
   endtask

   // Drive one cycle, advance the model, sample 1 time unit after the edge.
   task automatic cyc(input string nm, input logic v, input logic [31:0] d, input logic l, input logic ordy);
      in_valid  = v;
      in_data   = d;
      in_last   = l;
      out_ready = ordy;
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_edge(v, d, l, ordy);
      #1;
      if (err_frame === 1'b1) err_seen++;
      if (out_valid === 1'b1) valid_seen++;
      chk_model(nm);
   endtask

   task automatic send(input string nm, input int base, input int cnt, input int last_at,
                       input bit bubbles, input logic ordy);
      for (int i = 0; i < cnt; i++) begin
         if (bubbles) begin
            int nb = $urandom_range(0, 2);
            for (int b = 0; b < nb; b++) cyc(nm, 1'b0, $urandom, 1'b0, ordy);
         end
         cyc(nm, 1'b1, 32'(base + i), (i == last_at), ordy);
      end
   endtask

   initial begin
      total = 0; bad = 0; err_seen = 0; valid_seen = 0;
      rst_n = 1'b0; in_valid = 1'b1; in_data = 32'hdead_beef; in_last = 1'b0; out_ready = 1'b0;
      model_reset();

      // Stream 1..6 back-to-back, then the handoff and one idle cycle.
      for (int i = 0; i < 6; i++)
         tbl[i] = '{1'b1, 32'(i + 1), (i == 5), 1'b1, (i != 5), (i == 5), 1'b0};
      tbl[6] = '{1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[7] = '{1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

      // Reset held with in_valid high.
      for (int i = 0; i < 3; i++) cyc("rst_hold", 1'b1, 32'h1234_5678, 1'b0, 1'b0);
      chk("rst_mat_zero", out_mat, '0);
      chk("rst_ready_low", in_ready, 1'b0);
      rst_n = 1'b1;
      cyc("rst_release", 1'b1, 32'h55, 1'b0, 1'b0);
      chk("rst_ready_rise", in_ready, 1'b1);
      chk("rst_no_accept", out_mat, '0);

      for (int i = 0; i < 8; i++) begin
         cyc("tbl", tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].ordy);
         chk($sformatf("tbl%0d_rdy", i), in_ready, tbl[i].e_rdy);
         chk($sformatf("tbl%0d_val", i), out_valid, tbl[i].e_val);
         chk($sformatf("tbl%0d_err", i), err_frame, tbl[i].e_err);
      end
      chk("tbl_mat", out_mat, mk_mat(1));

      // Bubbles, then the consumer stalls while strays arrive.
      send("stall", 1, 6, 5, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) cyc("stall_hold", 1'b1, $urandom, $urandom_range(0, 1), 1'b0);
      chk("stall_mat", out_mat, mk_mat(1));
      chk("stall_val", out_valid, 1'b1);
      cyc("stall_release", 1'b0, 32'd0, 1'b0, 1'b1);
      chk("stall_rel_val", out_valid, 1'b0);
      chk("stall_rel_rdy", in_ready, 1'b1);

      // Early last.
      err_seen = 0; valid_seen = 0;
      send("early", 1, 4, 3, 1'b0, 1'b1);
      cyc("early_idle", 1'b0, 32'd0, 1'b0, 1'b1);
      chk("early_err_cnt", 32'(err_seen), 32'd1);
      chk("early_no_valid", 32'(valid_seen), 32'd0);
      send("refill", 10, 6, 5, 1'b0, 1'b0);
      chk("refill_mat", out_mat, mk_mat(10));
      cyc("refill_take", 1'b0, 32'd0, 1'b0, 1'b1);

      // Missing last.
      err_seen = 0;
      send("nolast", 1, 6, -1, 1'b0, 1'b0);
      cyc("nolast_idle", 1'b0, 32'd0, 1'b0, 1'b0);
      chk("nolast_err_cnt", 32'(err_seen), 32'd1);
      chk("nolast_val", out_valid, 1'b1);
      chk("nolast_mat", out_mat, mk_mat(1));
      cyc("nolast_take", 1'b0, 32'd0, 1'b0, 1'b1);

      // Reset in the middle of a frame.
      send("midrst", 21, 3, -1, 1'b0, 1'b0);
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      chk("midrst_val", out_valid, 1'b0);
      chk("midrst_rdy", in_ready, 1'b0);
      chk("midrst_mat", out_mat, '0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc("midrst_rel", 1'b0, 32'd0, 1'b0, 1'b0);
      send("post_rst", 7, 6, 5, 1'b0, 1'b0);
      chk("post_rst_mat", out_mat, mk_mat(7));
      cyc("post_rst_take", 1'b0, 32'd0, 1'b0, 1'b1);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++)
         cyc("rand", $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 5) == 0,
             $urandom_range(0, 2) != 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
